// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit; decode imports the same op codes.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/md_unit_if.sv
// E-stage request and HI/LO result bundle between the pipeline and md_unit.
interface md_unit_if;
    logic        start;
    logic [3:0]  md_op;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, flush, rs_data, rt_data,
        input  busy, rd_data, hi, lo
    );

    modport slave (
        input  start, md_op, flush, rs_data, rt_data,
        output busy, rd_data, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO; results computed at accept, committed after a fixed busy window.
// Latency MULT_CYCLES/DIV_CYCLES busy cycles; MTHI/MTLO take effect at the accept edge.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);

    localparam logic [CNT_W-1:0] LP_MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] LP_DIV_CNT  = CNT_W'(DIV_CYCLES);

    md_state_e         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]       r_hi, r_lo, w_hi_d, w_lo_d;
    logic [31:0]       r_hi_nxt, r_lo_nxt, w_hi_nxt_d, w_lo_nxt_d;

    md_op_e            w_op;
    logic              w_accept;

    logic [63:0]       w_prod_s, w_prod_u;
    logic              w_div_zero;
    logic [31:0]       w_divisor;
    logic              w_neg_a, w_neg_b;
    logic [31:0]       w_mag_a, w_mag_b;
    logic [31:0]       w_mag_q, w_mag_r;
    logic [31:0]       w_sq, w_sr;
    logic [31:0]       w_uq, w_ur;

    assign w_op     = md_op_e'(md.md_op);
    assign w_accept = md.start && !md.flush && (r_state == ST_IDLE);

    assign w_prod_s = $signed({{32{md.rs_data[31]}}, md.rs_data}) *
                      $signed({{32{md.rt_data[31]}}, md.rt_data});
    assign w_prod_u = {32'd0, md.rs_data} * {32'd0, md.rt_data};

    // A zero divisor is replaced by 1 so the dividers never see x/0; its result is discarded.
    assign w_div_zero = (md.rt_data == 32'd0);
    assign w_divisor  = w_div_zero ? 32'd1 : md.rt_data;

    // Signed divide through magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_neg_a = md.rs_data[31];
    assign w_neg_b = w_divisor[31];
    assign w_mag_a = w_neg_a ? (32'd0 - md.rs_data) : md.rs_data;
    assign w_mag_b = w_neg_b ? (32'd0 - w_divisor)  : w_divisor;
    assign w_mag_q = w_mag_a / w_mag_b;
    assign w_mag_r = w_mag_a % w_mag_b;
    assign w_sq    = (w_neg_a ^ w_neg_b) ? (32'd0 - w_mag_q) : w_mag_q;
    assign w_sr    = w_neg_a ? (32'd0 - w_mag_r) : w_mag_r;

    assign w_uq = md.rs_data / w_divisor;
    assign w_ur = md.rs_data % w_divisor;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_nxt <= '0;
            r_lo_nxt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_d;
            r_lo     <= w_lo_d;
            r_hi_nxt <= w_hi_nxt_d;
            r_lo_nxt <= w_lo_nxt_d;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_d      = r_hi;
        w_lo_d      = r_lo;
        w_hi_nxt_d  = r_hi_nxt;
        w_lo_nxt_d  = r_lo_nxt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_MULT: begin
                            {w_hi_nxt_d, w_lo_nxt_d} = w_prod_s;
                            w_cnt_nxt   = LP_MULT_CNT;
                            w_state_nxt = ST_BUSY;
                        end
                        OP_MULTU: begin
                            {w_hi_nxt_d, w_lo_nxt_d} = w_prod_u;
                            w_cnt_nxt   = LP_MULT_CNT;
                            w_state_nxt = ST_BUSY;
                        end
                        // Divide by zero stages the current HI/LO so the commit is a no-op.
                        OP_DIV: begin
                            w_hi_nxt_d  = w_div_zero ? r_hi : w_sr;
                            w_lo_nxt_d  = w_div_zero ? r_lo : w_sq;
                            w_cnt_nxt   = LP_DIV_CNT;
                            w_state_nxt = ST_BUSY;
                        end
                        OP_DIVU: begin
                            w_hi_nxt_d  = w_div_zero ? r_hi : w_ur;
                            w_lo_nxt_d  = w_div_zero ? r_lo : w_uq;
                            w_cnt_nxt   = LP_DIV_CNT;
                            w_state_nxt = ST_BUSY;
                        end
                        OP_MTHI: w_hi_d = md.rs_data;
                        OP_MTLO: w_lo_d = md.rs_data;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= 1) begin
                    w_hi_d      = r_hi_nxt;
                    w_lo_d      = r_lo_nxt;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign md.busy    = (r_state == ST_BUSY);
    assign md.hi      = r_hi;
    assign md.lo      = r_lo;
    assign md.rd_data = (w_op == OP_MFHI) ? r_hi :
                        (w_op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit against a plain-arithmetic HI/LO model.
module tb_md_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if u_if();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        u_if.start   = 1'b1;
        u_if.md_op   = op;
        u_if.rs_data = a;
        u_if.rt_data = b;
        u_if.flush   = fl;
        cyc();
        u_if.start   = 1'b0;
        u_if.flush   = 1'b0;
        u_if.md_op   = OP_NONE;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (u_if.busy === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
    endtask

    function automatic int latency(input md_op_e op);
        case (op)
            OP_MULT, OP_MULTU: return 5;
            OP_DIV, OP_DIVU:   return 10;
            default:           return 0;
        endcase
    endfunction

    // Architectural effect of one accepted instruction on HI/LO.
    task automatic model_apply(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        logic [63:0]     v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  begin sp = sa * sb; v = sp; m_hi = v[63:32]; m_lo = v[31:0]; end
            OP_MULTU: begin up = ua * ub; v = up; m_hi = v[63:32]; m_lo = v[31:0]; end
            OP_DIV: if (b != 0) begin
                sq = sa / sb; sr = sa % sb;
                v = sq; m_lo = v[31:0];
                v = sr; m_hi = v[31:0];
            end
            OP_DIVU: if (b != 0) begin
                uq = ua / ub; ur = ua % ub;
                v = uq; m_lo = v[31:0];
                v = ur; m_hi = v[31:0];
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        n_vec++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", u_if.busy); end
        n_vec++; if (u_if.hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", u_if.hi); end
        n_vec++; if (u_if.lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", u_if.lo); end
    endtask

    task automatic test_mul_div(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        int n;
        accept(op, a, b, 1'b0);
        model_apply(op, a, b);
        count_busy(n);
        n_vec++; if (n !== latency(op)) begin n_err++; $display("FAIL %s_busy_cycles got %0d want %0d", op.name(), n, latency(op)); end
        n_vec++; if (u_if.hi !== m_hi) begin n_err++; $display("FAIL %s_hi a=%h b=%h got %h want %h", op.name(), a, b, u_if.hi, m_hi); end
        n_vec++; if (u_if.lo !== m_lo) begin n_err++; $display("FAIL %s_lo a=%h b=%h got %h want %h", op.name(), a, b, u_if.lo, m_lo); end
        // Back-to-back MFLO in the first idle cycle sees the committed value.
        u_if.start = 1'b1;
        u_if.md_op = OP_MFLO;
        #1;
        n_vec++; if (u_if.rd_data !== m_lo) begin n_err++; $display("FAIL %s_mflo got %h want %h", op.name(), u_if.rd_data, m_lo); end
        cyc();
        u_if.start = 1'b0;
        u_if.md_op = OP_NONE;
    endtask

    task automatic test_mt_flush;
        accept(OP_MTLO, 32'h1234_5678, 32'd0, 1'b1);
        n_vec++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL mtlo_flush_busy got %b want 0", u_if.busy); end
        n_vec++; if (u_if.lo !== m_lo) begin n_err++; $display("FAIL mtlo_flush_lo got %h want %h", u_if.lo, m_lo); end
        accept(OP_MTLO, 32'h1234_5678, 32'd0, 1'b0);
        model_apply(OP_MTLO, 32'h1234_5678, 32'd0);
        n_vec++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy got %b want 0", u_if.busy); end
        n_vec++; if (u_if.lo !== 32'h1234_5678) begin n_err++; $display("FAIL mtlo_lo got %h want 12345678", u_if.lo); end
        u_if.md_op = OP_MFLO;
        #1;
        n_vec++; if (u_if.rd_data !== 32'h1234_5678) begin n_err++; $display("FAIL mflo_rd got %h want 12345678", u_if.rd_data); end
        accept(OP_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0);
        model_apply(OP_MTHI, 32'hCAFE_F00D, 32'd0);
        u_if.md_op = OP_MFHI;
        #1;
        n_vec++; if (u_if.rd_data !== m_hi) begin n_err++; $display("FAIL mfhi_rd got %h want %h", u_if.rd_data, m_hi); end
        u_if.md_op = OP_NONE;
        #1;
        n_vec++; if (u_if.rd_data !== 32'd0) begin n_err++; $display("FAIL none_rd got %h want 0", u_if.rd_data); end
    endtask

    task automatic test_flush_busy;
        int n;
        accept(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b0);
        model_apply(OP_DIV, 32'd1000, 32'hFFFF_FFF9);
        for (int c = 1; c <= 5; c++) begin
            u_if.flush   = (c == 3);
            u_if.start   = (c == 5);
            u_if.md_op   = (c == 5) ? OP_MULT : OP_NONE;
            u_if.rs_data = 32'h0000_1111;
            u_if.rt_data = 32'h0000_2222;
            cyc();
        end
        u_if.start = 1'b0;
        u_if.flush = 1'b0;
        u_if.md_op = OP_NONE;
        count_busy(n);
        n_vec++; if (n + 5 !== 10) begin n_err++; $display("FAIL flush_busy_cycles got %0d want 10", n + 5); end
        n_vec++; if (u_if.hi !== m_hi) begin n_err++; $display("FAIL flush_busy_hi got %h want %h", u_if.hi, m_hi); end
        n_vec++; if (u_if.lo !== m_lo) begin n_err++; $display("FAIL flush_busy_lo got %h want %h", u_if.lo, m_lo); end
    endtask

    task automatic test_reset_mid;
        accept(OP_MULT, 32'h0001_0003, 32'h0002_0005, 1'b0);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        n_vec++; if (u_if.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", u_if.busy); end
        n_vec++; if (u_if.hi !== 32'd0 || u_if.lo !== 32'd0) begin n_err++; $display("FAIL rstmid_hilo got %h/%h want 0/0", u_if.hi, u_if.lo); end
        for (int i = 0; i < 8; i++) cyc();
        n_vec++; if (u_if.hi !== 32'd0 || u_if.lo !== 32'd0 || u_if.busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_late_commit got %h/%h busy=%b want 0/0 busy=0", u_if.hi, u_if.lo, u_if.busy);
        end
    endtask

    task automatic test_random;
        md_op_e      op;
        logic [31:0] a, b;
        logic        fl;
        int          n, lat;
        for (int i = 0; i < 40; i++) begin
            op = md_op_e'($urandom_range(0, 8));
            a  = $urandom();
            b  = $urandom();
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 9);
                default: ;
            endcase
            fl = ($urandom_range(0, 7) == 0);
            u_if.md_op = op;
            #1;
            n_vec++;
            if (u_if.rd_data !== ((op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0)) begin
                n_err++; $display("FAIL rand%0d_rd op=%s got %h", i, op.name(), u_if.rd_data);
            end
            accept(op, a, b, fl);
            if (!fl) model_apply(op, a, b);
            lat = fl ? 0 : latency(op);
            count_busy(n);
            n_vec++; if (n !== lat) begin n_err++; $display("FAIL rand%0d_busy op=%s fl=%b got %0d want %0d", i, op.name(), fl, n, lat); end
            n_vec++; if (u_if.hi !== m_hi || u_if.lo !== m_lo) begin
                n_err++; $display("FAIL rand%0d_hilo op=%s a=%h b=%h fl=%b got %h/%h want %h/%h", i, op.name(), a, b, fl, u_if.hi, u_if.lo, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        u_if.start   = 1'b0;
        u_if.md_op   = OP_NONE;
        u_if.flush   = 1'b0;
        u_if.rs_data = 32'd0;
        u_if.rt_data = 32'd0;
        test_reset();
        test_mul_div(OP_MULT,  32'hFFFF_FFFE, 32'd3);
        test_mul_div(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        test_mul_div(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        test_mul_div(OP_DIVU,  32'd7,         32'd0);
        test_mul_div(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        test_mul_div(OP_DIV,   32'd7,         32'hFFFF_FFFE);
        test_mt_flush();
        test_flush_busy();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It consumes instructions that the decode control unit flags as multiply/divide class (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) and owns the HI/LO architectural registers. It models fixed multi-cycle latency through a busy window, during which decode stalls any further multiply/divide-class instruction. It honours the exception flush so that a cancelled instruction never alters HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  E-stage instruction is a valid MD op this cycle
- md_op  in  4  op code from md_pkg (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO)
- flush  in  1  exception/interrupt cancels the E-stage instruction this cycle
- rs_data  in  32  forwarded rs operand
- rt_data  in  32  forwarded rt operand
- busy  out  1  operation in flight; decode stalls MD-class instructions while start|busy
- rd_data  out  32  HI for MFHI, LO for MFLO, else 0 (combinational)
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- States: IDLE, BUSY. Down-counter `cnt` (4 bits). Pending registers `hi_nxt`, `lo_nxt`.
- Accept when `start & !flush & state==IDLE`:
  - MULT: `{hi_nxt,lo_nxt}` = signed 64-bit product; cnt=MULT_CYCLES; go BUSY.
  - MULTU: unsigned product; otherwise as MULT.
  - DIV: lo_nxt = signed quotient truncated toward zero; hi_nxt = remainder with the dividend's sign; cnt=DIV_CYCLES; go BUSY.
  - DIVU: unsigned quotient and remainder.
  - MTHI/MTLO: HI/LO ← rs_data at the same edge; stay IDLE.
  - MFHI/MFLO/NONE: no state change.
- Divide by zero (rt_data==0): still BUSY for DIV_CYCLES, but HI/LO are left unchanged at completion.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- BUSY: cnt decrements each cycle. On the edge where cnt==1: HI←hi_nxt, LO←lo_nxt (unless div-by-zero); go IDLE.
- flush does not abort an operation already in BUSY. Once accepted, an operation always completes.
- start while BUSY is a contract violation (decode guarantees the stall). The unit ignores it; HI/LO and cnt are unaffected.
- Reset: state=IDLE, cnt=0, HI=0, LO=0, hi_nxt=lo_nxt=0, busy=0.

## Timing
- busy = (state==BUSY). It is high starting the cycle after acceptance, for exactly MULT_CYCLES or DIV_CYCLES cycles.
- HI/LO hold their new values in the first cycle busy is low again. A back-to-back MFLO issued then reads the new value.
- MTHI/MTLO: visible on hi/lo and rd_data the cycle after the accept edge. busy never asserts.
- rd_data is combinational from the current HI/LO. It does not forward pending results; the stall covers this.
- Reset asserted mid-BUSY wins: IDLE and zeroed registers the next cycle, and no commit occurs.
- start and flush in the same cycle: nothing is accepted and busy stays low.

## Structure
- `md_pkg` holds:
  - the md_op encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8)
  - the IDLE/BUSY state constants
  - default latency constants
- The decode control unit imports the same encodings to drive md_op.
- Single module with no sub-modules. Arithmetic is computed at acceptance into the pending registers; the counter only models latency.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=2 → after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 7/0 → busy 10 cycles, HI/LO unchanged.
- MTLO rs=0x12345678 with flush=1 → LO unchanged, busy stays 0. Same without flush → LO=0x12345678 next cycle, and rd_data (MFLO) = 0x12345678.
- DIV accepted, flush asserted on cycle 3 of BUSY → operation completes and commits at cycle 10. start with MULT during BUSY → ignored.
- MULT accepted, reset on cycle 2 of BUSY → next cycle busy=0, HI=LO=0, and no later commit.
